// File: rtl/line_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : line_arbiter_if
//  Purpose  : Bundle of the three line-miss ports around the line arbiter:
//             the icache request/return port (i_*), the dcache request/return
//             port (d_*) and the adaptor LLC-side port (m_*).
//  Modports : slave  - the arbiter's view (caches request it, it drives m_*)
//             master - the environment's view (caches plus adaptor)
//  Revision : 1.0 - initial release
// ============================================================================
interface line_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
);
    // icache side
    logic              i_read;
    logic [ADDR_W-1:0] i_addr;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;
    // dcache side
    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_addr;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;
    // adaptor side
    logic              m_read;
    logic              m_write;
    logic [ADDR_W-1:0] m_addr;
    logic [LINE_W-1:0] m_wdata;
    logic [LINE_W-1:0] m_rdata;
    logic              m_resp;

    modport slave (
        input  i_read, i_addr,
        output i_rdata, i_resp,
        input  d_read, d_write, d_addr, d_wdata,
        output d_rdata, d_resp,
        output m_read, m_write, m_addr, m_wdata,
        input  m_rdata, m_resp
    );

    modport master (
        output i_read, i_addr,
        input  i_rdata, i_resp,
        output d_read, d_write, d_addr, d_wdata,
        input  d_rdata, d_resp,
        input  m_read, m_write, m_addr, m_wdata,
        output m_rdata, m_resp
    );
endinterface
`default_nettype wire

// File: rtl/line_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : line_arbiter
//  Purpose  : Round-robin arbiter forwarding one cache-line miss at a time
//             from the icache (read only) or dcache (read/writeback) to the
//             cacheline adaptor. Address and write data are latched at grant,
//             strobes are held until the adaptor responds, then the winner
//             gets its line (reads only) and a one-cycle resp.
//  Ports    : clk    - clock
//             reset  - synchronous active-high reset
//             bus    - line_arbiter_if.slave (i_*, d_*, m_* groups)
//  Revision : 1.0 - initial release
// ============================================================================
module line_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  wire logic       clk,
    input  wire logic       reset,
    line_arbiter_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_GRANT_I = 3'd1,
        S_GRANT_D = 3'd2,
        S_RESPOND = 3'd3,
        S_RECOVER = 3'd4
    } state_t;

    localparam logic c_side_i = 1'b0;
    localparam logic c_side_d = 1'b1;

    state_t            r_state;
    logic              r_last_grant;
    logic              r_m_read;
    logic              r_m_write;
    logic [ADDR_W-1:0] r_m_addr;
    logic [LINE_W-1:0] r_m_wdata;
    logic [LINE_W-1:0] r_i_rdata;
    logic [LINE_W-1:0] r_d_rdata;
    logic              r_i_resp;
    logic              r_d_resp;

    logic w_i_pend;
    logic w_d_pend;
    logic w_grant_d;

    assign w_i_pend  = bus.i_read;
    assign w_d_pend  = bus.d_read | bus.d_write;
    // On a tie the side that did not win last time goes first.
    assign w_grant_d = w_d_pend && (!w_i_pend || (r_last_grant == c_side_i));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_last_grant <= c_side_i;
            r_m_read     <= 1'b0;
            r_m_write    <= 1'b0;
            r_m_addr     <= '0;
            r_m_wdata    <= '0;
            r_i_rdata    <= '0;
            r_d_rdata    <= '0;
            r_i_resp     <= 1'b0;
            r_d_resp     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant_d) begin
                        r_m_addr     <= bus.d_addr;
                        r_m_wdata    <= bus.d_wdata;
                        // A simultaneous read+write is treated as a writeback.
                        r_m_write    <= bus.d_write;
                        r_m_read     <= ~bus.d_write;
                        r_last_grant <= c_side_d;
                        r_state      <= S_GRANT_D;
                    end else if (w_i_pend) begin
                        r_m_addr     <= bus.i_addr;
                        r_m_read     <= 1'b1;
                        r_m_write    <= 1'b0;
                        r_last_grant <= c_side_i;
                        r_state      <= S_GRANT_I;
                    end
                end
                S_GRANT_I: begin
                    if (bus.m_resp) begin
                        r_m_read  <= 1'b0;
                        r_m_write <= 1'b0;
                        r_i_rdata <= bus.m_rdata;
                        r_i_resp  <= 1'b1;
                        r_state   <= S_RESPOND;
                    end
                end
                S_GRANT_D: begin
                    if (bus.m_resp) begin
                        r_m_read  <= 1'b0;
                        r_m_write <= 1'b0;
                        // Writebacks return nothing; keep the last read line.
                        if (r_m_read) begin
                            r_d_rdata <= bus.m_rdata;
                        end
                        r_d_resp  <= 1'b1;
                        r_state   <= S_RESPOND;
                    end
                end
                S_RESPOND: begin
                    r_i_resp <= 1'b0;
                    r_d_resp <= 1'b0;
                    r_state  <= S_RECOVER;
                end
                // Dead cycle: requester drops its strobe, adaptor settles.
                S_RECOVER: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.m_read  = r_m_read;
    assign bus.m_write = r_m_write;
    assign bus.m_addr  = r_m_addr;
    assign bus.m_wdata = r_m_wdata;
    assign bus.i_rdata = r_i_rdata;
    assign bus.i_resp  = r_i_resp;
    assign bus.d_rdata = r_d_rdata;
    assign bus.d_resp  = r_d_resp;

endmodule
`default_nettype wire
